// File: rtl/fl_frame_arbiter.sv
// Round-robin, frame-granular FrameLink merger: PORTS input streams share one output,
// and a granted port keeps the output until its EOF beat has transferred.
module fl_frame_arbiter #(
    parameter int PORTS     = 4,
    parameter int DWIDTH    = 32,
    parameter int DREMWIDTH = 2,
    parameter int CNTWIDTH  = 32,
    localparam int GW       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [PORTS*DWIDTH-1:0]    RX_DATA,
    input  logic [PORTS*DREMWIDTH-1:0] RX_DREM,
    input  logic [PORTS-1:0]           RX_SOF_N,
    input  logic [PORTS-1:0]           RX_EOF_N,
    input  logic [PORTS-1:0]           RX_SOP_N,
    input  logic [PORTS-1:0]           RX_EOP_N,
    input  logic [PORTS-1:0]           RX_SRC_RDY_N,
    output logic [PORTS-1:0]           RX_DST_RDY_N,
    output logic [DWIDTH-1:0]          TX_DATA,
    output logic [DREMWIDTH-1:0]       TX_DREM,
    output logic                       TX_SOF_N,
    output logic                       TX_EOF_N,
    output logic                       TX_SOP_N,
    output logic                       TX_EOP_N,
    output logic                       TX_SRC_RDY_N,
    input  logic                       TX_DST_RDY_N,
    input  logic [PORTS-1:0]           PORT_EN,
    output logic                       ACTIVE,
    output logic [GW-1:0]              GRANT,
    output logic [CNTWIDTH-1:0]        FRAME_CNT
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         last_q, last_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [CNTWIDTH-1:0]   cnt_q, cnt_d;

    logic [PORTS-1:0]      req;
    logic                  found;
    logic [GW-1:0]         winner;
    logic [GW-1:0]         idx;
    logic                  xfer;

    logic [DWIDTH-1:0]     rx_data_a [PORTS];
    logic [DREMWIDTH-1:0]  rx_drem_a [PORTS];

    for (genvar i = 0; i < PORTS; i++) begin : g_unpack
        assign rx_data_a[i] = RX_DATA[i*DWIDTH +: DWIDTH];
        assign rx_drem_a[i] = RX_DREM[i*DREMWIDTH +: DREMWIDTH];
    end

    assign req  = ~RX_SRC_RDY_N & PORT_EN;
    assign xfer = ~RX_SRC_RDY_N[grant_q] & ~TX_DST_RDY_N;

    // Search starts one past the last frame owner, so the previous winner goes last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        found  = 1'b0;
        winner = last_q;
        idx    = last_q;
        for (int k = 1; k <= PORTS; k++) begin
            idx = GW'((int'(last_q) + k) % PORTS);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (xfer && !RX_EOF_N[grant_q]) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    cnt_d   = cnt_q + CNTWIDTH'(1);
                end
            end
        endcase
    end

    // Outputs are muted directly by RESET_N so a truncated frame stops on the reset cycle.
    always_comb begin
        TX_DATA      = '0;
        TX_DREM      = '0;
        TX_SOF_N     = 1'b1;
        TX_EOF_N     = 1'b1;
        TX_SOP_N     = 1'b1;
        TX_EOP_N     = 1'b1;
        TX_SRC_RDY_N = 1'b1;
        RX_DST_RDY_N = '1;
        if (RESET_N && state_q == LOCK) begin
            TX_DATA               = rx_data_a[grant_q];
            TX_DREM               = rx_drem_a[grant_q];
            TX_SOF_N              = RX_SOF_N[grant_q];
            TX_EOF_N              = RX_EOF_N[grant_q];
            TX_SOP_N              = RX_SOP_N[grant_q];
            TX_EOP_N              = RX_EOP_N[grant_q];
            TX_SRC_RDY_N          = RX_SRC_RDY_N[grant_q];
            RX_DST_RDY_N[grant_q] = TX_DST_RDY_N;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so all of them update together.
        if (!RESET_N) begin
            state_q <= IDLE;
            last_q  <= GW'(PORTS - 1);
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ACTIVE    = (state_q == LOCK);
    assign GRANT     = grant_q;
    assign FRAME_CNT = cnt_q;

endmodule

// File: tb/tb_fl_frame_arbiter.sv
// Directed bench for fl_frame_arbiter: a frame-level model checked every cycle,
// plus literal expectations for grant order, counter values and reset behaviour.
module tb_fl_frame_arbiter;

    localparam int PORTS = 4;
    localparam int DW    = 32;
    localparam int RW    = 2;
    localparam int CW    = 4;

    logic                  CLK = 1'b0;
    logic                  RESET_N = 1'b0;
    logic [PORTS*DW-1:0]   RX_DATA = '0;
    logic [PORTS*RW-1:0]   RX_DREM = '0;
    logic [PORTS-1:0]      RX_SOF_N = '1, RX_EOF_N = '1, RX_SOP_N = '1, RX_EOP_N = '1;
    logic [PORTS-1:0]      RX_SRC_RDY_N = '1;
    logic [PORTS-1:0]      RX_DST_RDY_N;
    logic [DW-1:0]         TX_DATA;
    logic [RW-1:0]         TX_DREM;
    logic                  TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N;
    logic                  TX_DST_RDY_N = 1'b0;
    logic [PORTS-1:0]      PORT_EN = '1;
    logic                  ACTIVE;
    logic [1:0]            GRANT;
    logic [CW-1:0]         FRAME_CNT;

    fl_frame_arbiter #(
        .PORTS(PORTS), .DWIDTH(DW), .DREMWIDTH(RW), .CNTWIDTH(CW)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .RX_DATA(RX_DATA), .RX_DREM(RX_DREM),
        .RX_SOF_N(RX_SOF_N), .RX_EOF_N(RX_EOF_N), .RX_SOP_N(RX_SOP_N), .RX_EOP_N(RX_EOP_N),
        .RX_SRC_RDY_N(RX_SRC_RDY_N), .RX_DST_RDY_N(RX_DST_RDY_N),
        .TX_DATA(TX_DATA), .TX_DREM(TX_DREM),
        .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N), .TX_SOP_N(TX_SOP_N), .TX_EOP_N(TX_EOP_N),
        .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N),
        .PORT_EN(PORT_EN), .ACTIVE(ACTIVE), .GRANT(GRANT), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- frame-level reference model ----------------
    logic          m_active = 1'b0;
    logic [1:0]    m_grant  = 2'd0;
    logic [1:0]    m_last   = 2'd3;
    logic [CW-1:0] m_cnt    = '0;
    logic          check_en = 1'b0;

    // Winner is the enabled requester closest after the last owner, going round the ring.
    function automatic int rr_pick(input logic [PORTS-1:0] reqs, input int last);
        int best = -1;
        int best_dist = PORTS;
        for (int i = 0; i < PORTS; i++) begin
            if (reqs[i] && ((i - last - 1 + 2*PORTS) % PORTS) < best_dist) begin
                best_dist = (i - last - 1 + 2*PORTS) % PORTS;
                best = i;
            end
        end
        return best;
    endfunction

    always @(posedge CLK) begin
        if (!RESET_N) begin
            m_active <= 1'b0;
            m_last   <= 2'd3;
            m_grant  <= 2'd0;
            m_cnt    <= '0;
        end else if (m_active) begin
            if (!RX_SRC_RDY_N[m_grant] && !TX_DST_RDY_N && !RX_EOF_N[m_grant]) begin
                m_active <= 1'b0;
                m_last   <= m_grant;
                m_cnt    <= m_cnt + CW'(1);
            end
        end else if (rr_pick(~RX_SRC_RDY_N & PORT_EN, int'(m_last)) >= 0) begin
            m_active <= 1'b1;
            m_grant  <= 2'(rr_pick(~RX_SRC_RDY_N & PORT_EN, int'(m_last)));
        end
    end

    logic [DW-1:0]    e_data;
    logic [RW+4:0]    e_ctrl;
    logic [PORTS-1:0] e_dst;

    always_comb begin
        e_data = '0;
        e_ctrl = {{RW{1'b0}}, 5'b11111};
        e_dst  = '1;
        if (m_active) begin
            e_data = RX_DATA[int'(m_grant)*DW +: DW];
            e_ctrl = {RX_DREM[int'(m_grant)*RW +: RW], RX_SOF_N[m_grant], RX_EOF_N[m_grant],
                      RX_SOP_N[m_grant], RX_EOP_N[m_grant], RX_SRC_RDY_N[m_grant]};
            e_dst[m_grant] = TX_DST_RDY_N;
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            if (!RESET_N) begin
                check("rst_tx_src", 64'(TX_SRC_RDY_N), 64'(1'b1));
                check("rst_rx_dst", 64'(RX_DST_RDY_N), 64'(4'hF));
            end else begin
                check("tx_data", 64'(TX_DATA), 64'(e_data));
                check("tx_ctrl", 64'({TX_DREM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N}),
                      64'(e_ctrl));
                check("rx_dst", 64'(RX_DST_RDY_N), 64'(e_dst));
            end
            check("active", 64'(ACTIVE), 64'(m_active));
            check("grant", 64'(GRANT), 64'(m_grant));
            check("frame_cnt", 64'(FRAME_CNT), 64'(m_cnt));
        end
    end

    // ---------------- per-port frame sources ----------------
    int               n_frames [PORTS];
    int               flen     [PORTS];
    int               beat     [PORTS];
    int               fid      [PORTS];
    logic [PORTS-1:0] frame_done = '0;
    int               grant_log[$];
    int               exp_q[$];
    logic             prev_active = 1'b0;

    task automatic drive();
        for (int p = 0; p < PORTS; p++) begin
            RX_SRC_RDY_N[p]     = !(n_frames[p] > 0);
            RX_SOF_N[p]         = !(beat[p] == 0);
            RX_EOF_N[p]         = !(beat[p] == flen[p] - 1);
            RX_SOP_N[p]         = RX_SOF_N[p];
            RX_EOP_N[p]         = RX_EOF_N[p];
            RX_DATA[p*DW +: DW] = {8'(p), 8'(fid[p]), 16'(beat[p])};
            RX_DREM[p*RW +: RW] = RW'(beat[p] + p);
        end
    endtask

    task automatic load(input int p, input int frames, input int len);
        n_frames[p] = frames;
        flen[p]     = len;
        beat[p]     = 0;
        drive();
    endtask

    task automatic clear_sources();
        for (int p = 0; p < PORTS; p++) begin
            n_frames[p] = 0;
            flen[p]     = 1;
            beat[p]     = 0;
            fid[p]      = 0;
        end
        drive();
    endtask

    // One clock: sample handshakes away from the edge, then advance sources after it.
    task automatic cycle();
        logic [PORTS-1:0] xf;
        @(negedge CLK);
        xf = ~RX_DST_RDY_N & ~RX_SRC_RDY_N;
        if (ACTIVE && !prev_active) grant_log.push_back(int'(GRANT));
        prev_active = ACTIVE;
        @(posedge CLK);
        #1;
        frame_done = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (xf[p]) begin
                beat[p]++;
                if (beat[p] == flen[p]) begin
                    beat[p] = 0;
                    n_frames[p]--;
                    fid[p]++;
                    frame_done[p] = 1'b1;
                end
            end
        end
        drive();
    endtask

    function automatic bit pending();
        bit any = 1'b0;
        for (int p = 0; p < PORTS; p++) if (n_frames[p] > 0) any = 1'b1;
        return any;
    endfunction

    task automatic run_until_idle(input string name, input int budget, output int n);
        n = 0;
        while ((pending() || ACTIVE) && n < budget) begin
            cycle();
            n++;
        end
        check({"done_", name}, 64'(n < budget), 64'(1));
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, 64'(grant_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < grant_log.size()) check($sformatf("%s_%0d", name, i), 64'(grant_log[i]), 64'(exp_q[i]));
        end
    endtask

    task automatic do_reset();
        RESET_N      = 1'b0;
        TX_DST_RDY_N = 1'b0;
        PORT_EN      = '1;
        clear_sources();
        cycle();
        check_en = 1'b1;
        cycle();
        RESET_N = 1'b1;
        grant_log.delete();
        prev_active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int done;

        // Reset state
        do_reset();
        check("rst_active", 64'(ACTIVE), 64'(0));
        check("rst_grant", 64'(GRANT), 64'(0));
        check("rst_cnt", 64'(FRAME_CNT), 64'(0));
        check("rst_src", 64'(TX_SRC_RDY_N), 64'(1));

        // Single source: port 2, one 3-beat frame
        load(2, 1, 3);
        n = 0;
        while (!ACTIVE && n < 10) begin cycle(); n++; end
        check("single_idle_cycles", 64'(n), 64'(1));
        check("single_dst", 64'(RX_DST_RDY_N), 64'(4'b1011));
        check("single_beat0", 64'(TX_DATA), 64'(32'h0200_0000));
        check("single_sof", 64'(TX_SOF_N), 64'(0));
        run_until_idle("single", 20, n);
        check("single_cnt", 64'(FRAME_CNT), 64'(1));
        check("single_grant", 64'(GRANT), 64'(2));

        // Round-robin fairness
        do_reset();
        load(0, 2, 2);
        load(1, 1, 2);
        load(2, 1, 2);
        load(3, 1, 2);
        run_until_idle("rr", 100, n);
        check("rr_cycles", 64'(n), 64'(15));
        exp_q = {0, 1, 2, 3, 0};
        check_log("rr_order");
        check("rr_cnt", 64'(FRAME_CNT), 64'(5));

        // Backpressure on port 1 while port 3 waits
        do_reset();
        load(1, 1, 4);
        load(3, 1, 2);
        n = 0;
        while (!ACTIVE && n < 10) begin cycle(); n++; end
        cycle();
        TX_DST_RDY_N = 1'b1;
        repeat (4) begin
            #1;
            check("bp_data", 64'(TX_DATA), 64'(32'h0100_0001));
            check("bp_dst", 64'(RX_DST_RDY_N), 64'(4'b1111));
            check("bp_grant", 64'(GRANT), 64'(1));
            cycle();
        end
        TX_DST_RDY_N = 1'b0;
        run_until_idle("bp", 50, n);
        exp_q = {1, 3};
        check_log("bp_order");

        // Enable mask, with port 1 disabled during its second frame
        do_reset();
        PORT_EN = 4'b1010;
        load(0, 2, 2);
        load(1, 2, 3);
        load(2, 2, 2);
        load(3, 2, 2);
        n = 0;
        while ((n_frames[1] > 0 || n_frames[3] > 0 || ACTIVE) && n < 200) begin
            cycle();
            n++;
            if (grant_log.size() == 3 && ACTIVE && GRANT == 2'd1 && beat[1] == 1) PORT_EN[1] = 1'b0;
        end
        check("en_done", 64'(n < 200), 64'(1));
        check("en_port1_disabled", 64'(PORT_EN), 64'(4'b1000));
        repeat (3) cycle();
        check("en_idle", 64'(ACTIVE), 64'(0));
        exp_q = {1, 3, 1, 3};
        check_log("en_order");

        // Reset in the middle of a frame from port 0, after port 1 was last owner
        do_reset();
        load(1, 1, 2);
        run_until_idle("pre_rst", 20, n);
        load(0, 1, 4);
        n = 0;
        while (beat[0] != 2 && n < 20) begin cycle(); n++; end
        RESET_N = 1'b0;
        #1;
        check("midrst_src", 64'(TX_SRC_RDY_N), 64'(1));
        check("midrst_dst", 64'(RX_DST_RDY_N), 64'(4'b1111));
        clear_sources();
        repeat (2) cycle();
        RESET_N = 1'b1;
        #1;
        check("midrst_cnt", 64'(FRAME_CNT), 64'(0));
        check("midrst_active", 64'(ACTIVE), 64'(0));
        grant_log.delete();
        prev_active = 1'b0;
        for (int p = 0; p < PORTS; p++) load(p, 1, 1);
        run_until_idle("post_rst", 50, n);
        exp_q = {0, 1, 2, 3};
        check_log("midrst_order");

        // Single-beat frames and counter wrap
        do_reset();
        load(0, 17, 1);
        n = 0;
        done = 0;
        while ((pending() || ACTIVE) && n < 100) begin
            cycle();
            n++;
            if (frame_done[0]) begin
                done++;
                if (done == 15) check("wrap_15", 64'(FRAME_CNT), 64'(15));
                if (done == 16) check("wrap_16", 64'(FRAME_CNT), 64'(0));
                if (done == 17) check("wrap_17", 64'(FRAME_CNT), 64'(1));
            end
        end
        check("wrap_frames", 64'(done), 64'(17));
        check("wrap_cycles", 64'(n), 64'(34));

        repeat (2) cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fl_frame_arbiter.md
Name: fl_frame_arbiter

Overview:
- Merges PORTS FrameLink input streams onto a single FrameLink output.
- Arbitration is round-robin and frame-granular: once a port is granted, it owns the output until its EOF beat transfers.
- Sits in front of shared FrameLink consumers (DMA, output buffers) so that several producers can share one datapath without interleaving frames.
- Also provides a per-port enable mask and status outputs for software/monitoring.

Parameters:
- PORTS, 4, number of input FrameLink ports (>=2).
- DWIDTH, 32, FrameLink data width.
- DREMWIDTH, 2, FrameLink DREM width (log2(DWIDTH/8)).
- CNTWIDTH, 32, width of the forwarded-frame counter.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RESET_N  in  1  reset, synchronous, active low.
- RX_DATA  in  PORTS*DWIDTH  input data; port i occupies bits [i*DWIDTH +: DWIDTH].
- RX_DREM  in  PORTS*DREMWIDTH  input data remainder, packed the same way.
- RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  PORTS each  input framing signals, active low, one bit per port.
- RX_SRC_RDY_N  in  PORTS  input source ready, active low.
- RX_DST_RDY_N  out  PORTS  input destination ready, active low.
- TX_DATA  out  DWIDTH  output data.
- TX_DREM  out  DREMWIDTH  output data remainder.
- TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  1 each  output framing signals, active low.
- TX_SRC_RDY_N  out  1  output source ready, active low.
- TX_DST_RDY_N  in  1  output destination ready, active low.
- PORT_EN  in  PORTS  per-port arbitration enable (1 = may be granted).
- ACTIVE  out  1  1 while a frame is locked to a port.
- GRANT  out  clog2(PORTS)  index of the locked or most recently locked port.
- FRAME_CNT  out  CNTWIDTH  count of frames forwarded; wraps modulo 2^CNTWIDTH.

Behaviour:
- Reset (RESET_N=0 at a rising edge):
  - state <= IDLE, LAST <= PORTS-1 (so port 0 has first priority), GRANT <= 0, FRAME_CNT <= 0.
  - While RESET_N=0, all RX_DST_RDY_N=1 and TX_SRC_RDY_N=1, combinationally (not waiting for the edge).
- Transfer definition: a beat transfers on port g when RX_SRC_RDY_N[g]=0 and TX_DST_RDY_N=0 in the same cycle.
- FSM with two states, IDLE and LOCK:
  - IDLE, request: port i requests when RX_SRC_RDY_N[i]=0 and PORT_EN[i]=1.
  - IDLE, winner: the first requesting port searching LAST+1, LAST+2, ... modulo PORTS.
  - IDLE, on a winner: GRANT <= winner and state <= LOCK at the next edge.
  - IDLE, outputs: no beat is forwarded. TX_SRC_RDY_N=1, all RX_DST_RDY_N=1, TX data/DREM/framing driven to 0/1 (inactive).
  - The one-cycle arbitration bubble per frame is intended.
  - LOCK, datapath: TX_DATA, TX_DREM, all four TX framing signals and TX_SRC_RDY_N = the corresponding RX signals of port GRANT.
  - LOCK, ready routing: RX_DST_RDY_N[GRANT] = TX_DST_RDY_N; every other RX_DST_RDY_N = 1.
  - Combinational path latency through the block is 0.
  - LOCK, frame end: on a transfer with RX_EOF_N[GRANT]=0 → state <= IDLE, LAST <= GRANT, FRAME_CNT <= FRAME_CNT+1.
  - LOCK, otherwise: remain in LOCK; stalls on either side hold the lock indefinitely.
- Single-beat frame (SOF=EOF=0 on the same beat): counts as one frame, returns to IDLE after that one transfer.
- PORT_EN cleared mid-frame: does not abort the frame; it only affects the next IDLE arbitration.
- No requesters, or all requesters disabled: stay in IDLE; LAST is unchanged.
- Granted port not at SOF: no protocol checking; the arbiter relies only on EOF for frame boundaries.
- ACTIVE = (state==LOCK). GRANT holds its value after returning to IDLE.
- Reset mid-frame: the frame is truncated. Outputs go inactive immediately while RESET_N=0. After release, arbitration restarts with port 0 first; FRAME_CNT is not incremented for the truncated frame.
- FRAME_CNT wraps from 2^CNTWIDTH-1 to 0.

Test Plan:
- Single source: PORTS=4, only port 2 sends a 3-beat frame, TX_DST_RDY_N=0.
  - IDLE cycle, then 3 TX beats carrying port 2 data in order; RX_DST_RDY_N = 4'b1011 during LOCK.
  - After the frame: FRAME_CNT=1, GRANT=2.
- Round-robin fairness: all 4 ports request continuously with 2-beat frames.
  - Grant order 0,1,2,3,0; one bubble cycle between frames; FRAME_CNT=5 after 5 frames.
- Backpressure: port 1 is locked, TX_DST_RDY_N=1 for 4 cycles mid-frame while port 3 requests.
  - Lock is held; TX data is stable; RX_DST_RDY_N[1]=1 while stalled.
  - Port 3 is granted only after port 1's EOF transfer.
- Enable mask: PORT_EN=4'b1010, all ports requesting.
  - Only ports 1 and 3 are granted, alternating.
  - Clearing PORT_EN[1] during port 1's frame still completes that frame.
- Reset mid-frame: RESET_N=0 on beat 2 of a 4-beat frame from port 0.
  - Same cycle: TX_SRC_RDY_N=1 and RX_DST_RDY_N=4'b1111.
  - After release: FRAME_CNT=0, ACTIVE=0, port 0 has first priority.
- Single-beat frames and wrap: CNTWIDTH=4, 17 single-beat frames from port 0.
  - Each frame is 1 beat followed by 1 IDLE cycle.
  - FRAME_CNT reads 15 after 15 frames, 0 after the 16th, 1 after the 17th.
